// File: rtl/ram_burst_controller_pkg.sv
// Shared definitions for the RAM burst initiator: state encoding,
// default bus widths and the supported read-latency window.
package ram_burst_controller_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH = 4;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;

  // The wait counter is loaded with latency-1, so it only needs to hold 0..MAX-1.
  localparam int WAIT_WIDTH = $clog2(READ_LATENCY_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BEAT = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

endpackage

// File: rtl/ram_burst_controller.sv
// Burst initiator for the single-port RAM bank wrapper: one RAM access per beat,
// write beats streamed in via valid/ready, read beats streamed out via valid/ready.
module ram_burst_controller
  import ram_burst_controller_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [ADDR_WIDTH-1:0] cmd_length,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_last,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_read_mode,
  output logic                  ram_write_mode,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy,
  output logic                  done
);

  // Out-of-range latencies saturate to the supported window.
  localparam int LATENCY = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                           (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                           READ_LATENCY;
  localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(LATENCY - 1);

  state_t                  state_reg,   state_next;
  logic [ADDR_WIDTH-1:0]   address_reg, address_next;
  logic [ADDR_WIDTH-1:0]   length_reg,  length_next;
  logic [ADDR_WIDTH-1:0]   beat_reg,    beat_next;
  logic [WAIT_WIDTH-1:0]   wait_reg,    wait_next;
  logic [DATA_WIDTH-1:0]   rdata_reg,   rdata_next;
  logic                    done_reg,    done_next;
  logic                    last_beat;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      address_reg <= '0;
      length_reg  <= '0;
      beat_reg    <= '0;
      wait_reg    <= '0;
      rdata_reg   <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      address_reg <= address_next;
      length_reg  <= length_next;
      beat_reg    <= beat_next;
      wait_reg    <= wait_next;
      rdata_reg   <= rdata_next;
      done_reg    <= done_next;
    end
  end

  assign last_beat = (beat_reg == length_reg);

  always_comb begin
    state_next     = state_reg;
    address_next   = address_reg;
    length_next    = length_reg;
    beat_next      = beat_reg;
    wait_next      = wait_reg;
    rdata_next     = rdata_reg;
    done_next      = 1'b0;
    cmd_ready      = 1'b0;
    wdata_ready    = 1'b0;
    rdata_valid    = 1'b0;
    rdata_last     = 1'b0;
    ram_data       = '0;
    ram_read_mode  = 1'b0;
    ram_write_mode = 1'b0;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          address_next = cmd_address;
          length_next  = cmd_length;
          beat_next    = '0;
          state_next   = cmd_write ? WR_BEAT : RD_ADDR;
        end
      end

      WR_BEAT: begin
        wdata_ready    = 1'b1;
        ram_data       = wdata;
        // The RAM commits on the same edge that completes the beat handshake.
        ram_write_mode = wdata_valid;
        if (wdata_valid) begin
          if (last_beat) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            address_next = address_reg + 1'b1;
            beat_next    = beat_reg + 1'b1;
          end
        end
      end

      RD_ADDR: begin
        ram_read_mode = 1'b1;
        wait_next     = WAIT_LOAD;
        state_next    = RD_WAIT;
      end

      RD_WAIT: begin
        ram_read_mode = 1'b1;
        if (wait_reg == '0) begin
          rdata_next = ram_data_out;
          state_next = RD_HOLD;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end

      RD_HOLD: begin
        rdata_valid = 1'b1;
        rdata_last  = last_beat;
        if (rdata_ready) begin
          if (last_beat) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            address_next = address_reg + 1'b1;
            beat_next    = beat_reg + 1'b1;
            state_next   = RD_ADDR;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign ram_address = address_reg;
  assign rdata       = rdata_reg;
  assign busy        = (state_reg != IDLE);
  assign done        = done_reg;

endmodule
